// File: rtl/psk_pkg.sv
// Shared types for the PSK bit-gathering path: assembler state encoding and
// the rule that sizes the per-symbol bit counter.
package psk_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

  // Bits needed to index a position within an n-bit symbol.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry symbol buffer between the bit assembler and the downstream consumer.
// A push into a full buffer is accepted only when a pop happens on the same edge.
module sym_fifo2 #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [M-1:0] din,
  output logic [M-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [1:0]   count;
  logic [M-1:0] e0;
  logic [M-1:0] e1;
  logic         do_pop;
  logic         do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is qualified by count, so it needs no reset; e0 is always the head.
  always_ff @(posedge clk) begin
    if (do_push && (count == 2'd0 || (count == 2'd1 && do_pop)))
      e0 <= din;
    else if (do_pop)
      e0 <= e1;
    if (do_push && (count == 2'd2 || (count == 2'd1 && !do_pop)))
      e1 <= din;
  end

endmodule

// File: rtl/bits_gather.sv
// Gathers serial bits LSB-first into N-bit symbols (or one bit per symbol in
// BPSK bypass) and queues them in a 2-entry buffer for the downstream stage.
module bits_gather
  import psk_pkg::*;
#(
  parameter int N                = 2,
  parameter int M                = 8,
  parameter int BYPASS_SELECTION = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bypass,
  input  logic         bit_in,
  input  logic         bit_valid,
  input  logic         sym_start,
  input  logic         sym_ready,
  output logic [M-1:0] sym_out,
  output logic         sym_valid,
  output logic         frame_err,
  output logic         overflow
);

  localparam int CNT_W = cnt_width(N);

  asm_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     part;
  logic [N-1:0]     merged;
  logic             push;
  logic [M-1:0]     push_data;
  logic             ferr_next;
  logic             pop;
  logic             full;
  logic             empty;
  logic             last_bit;

  assign last_bit  = (cnt == CNT_W'(N - 1));
  assign sym_valid = ~empty;
  assign pop       = sym_valid & sym_ready;

  always_comb begin
    merged    = part | (N'(bit_in) << cnt);
    push      = 1'b0;
    push_data = '0;
    ferr_next = 1'b0;
    if (bypass) begin
      push      = bit_valid;
      push_data = M'(bit_in) << BYPASS_SELECTION;
    end else if (bit_valid && state == COLLECT) begin
      if (sym_start) begin
        ferr_next = 1'b1;
      end else if (last_bit) begin
        push      = 1'b1;
        push_data = M'(merged);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      part      <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= ferr_next;
      overflow  <= push & full & ~pop;
      // Bypass owns the datapath; any half-built symbol is silently dropped.
      if (bypass) begin
        state <= IDLE;
        cnt   <= '0;
        part  <= '0;
      end else if (bit_valid) begin
        case (state)
          IDLE: begin
            if (sym_start) begin
              part  <= N'(bit_in);
              cnt   <= CNT_W'(1);
              state <= COLLECT;
            end
          end
          COLLECT: begin
            if (sym_start) begin
              part <= N'(bit_in);
              cnt  <= CNT_W'(1);
            end else if (last_bit) begin
              part  <= '0;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              part <= merged;
              cnt  <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sym_fifo2 #(
    .M(M)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (push_data),
    .dout (sym_out),
    .empty(empty),
    .full (full)
  );

endmodule

// File: doc/bits_gather.md
BITS_GATHER -- requirements
Module: bits_gather

Interface
REQ-001 Parameter N, default 2, meaning bits per symbol; legal range 2..M.
REQ-002 Parameter M, default 8, meaning output symbol width; bits M-1:N are always 0.
REQ-003 Parameter BYPASS_SELECTION, default 1, meaning symbol bit position loaded in bypass (BPSK) mode; legal range 0..N-1.
REQ-004 clk  input  1  single clock, the high-rate serial-bit clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 bypass  input  1  high selects BPSK mode, where one bit equals one symbol.
REQ-007 bit_in  input  1  serial data bit.
REQ-008 bit_valid  input  1  bit_in is valid this cycle.
REQ-009 sym_start  input  1  qualified by bit_valid; marks the first bit of a symbol.
REQ-010 sym_ready  input  1  downstream accepts sym_out this cycle.
REQ-011 sym_out  output  M  assembled symbol, head of the output buffer.
REQ-012 sym_valid  output  1  sym_out holds a valid symbol.
REQ-013 frame_err  output  1  one-cycle pulse when a symbol is abandoned before completion.
REQ-014 overflow  output  1  one-cycle pulse when a completed symbol is dropped because the buffer is full.

Function
REQ-015 Bit order SHALL be LSB first: the bit carrying sym_start goes to sym_out[0], and the k-th following valid bit goes to sym_out[k].
REQ-016 Assembler FSM SHALL have states IDLE and COLLECT, plus a bit counter cnt of width $clog2(N).
REQ-017 IDLE transitions:
- bit_valid & sym_start: write bit_in to position 0, set cnt=1, go to COLLECT.
- bit_valid without sym_start: discard the bit, stay in IDLE, no error.
REQ-018 COLLECT transitions:
- bit_valid & !sym_start: write bit_in at position cnt, then cnt+1.
- When the written position is N-1: the symbol is complete; push it to the buffer and return to IDLE.
REQ-019 COLLECT with bit_valid & sym_start before completion:
- pulse frame_err for one cycle;
- discard the partial symbol;
- restart with bit_in at position 0 and cnt=1; state stays COLLECT.
REQ-020 COLLECT cycles without bit_valid SHALL hold state, cnt and partial data unchanged; there is no timeout.
REQ-021 In bypass mode, every bit_valid SHALL push one symbol with bit_in at BYPASS_SELECTION and all other bits 0; sym_start is ignored.
REQ-022 When bypass rises, any partial symbol SHALL be discarded without frame_err, and the FSM goes to IDLE.
REQ-023 Output buffer SHALL be a 2-entry FIFO:
- sym_valid = not empty;
- sym_out = head entry, 0 when empty;
- pop when sym_valid & sym_ready.
REQ-024 Latency: a completed symbol SHALL appear on sym_out with sym_valid high on the first cycle after the rising edge that sampled its last bit, when the buffer was empty.
REQ-025 Push into a full buffer with a simultaneous pop SHALL succeed with no overflow.
REQ-026 Push into a full buffer without a pop SHALL drop the new symbol and pulse overflow; stored entries remain unchanged.
REQ-027 frame_err and overflow SHALL never be asserted longer than one cycle per event.

Reset
REQ-028 On rst_n low, all of the following SHALL clear immediately and asynchronously:
- FSM to IDLE, cnt=0, partial data=0;
- FIFO empty;
- sym_out=0, sym_valid=0, frame_err=0, overflow=0.
REQ-029 Reset asserted mid-symbol or with a full buffer SHALL discard all data; the first symbol after reset requires a new sym_start.

Structure
REQ-030 Shared package psk_pkg SHALL hold the FSM state type (IDLE, COLLECT) and the CNT_WIDTH=$clog2(N) rule.
REQ-031 The 2-entry buffer SHALL be a separate sub-module sym_fifo2 (parameter width M; ports push, pop, din, dout, empty, full).

Verification (N=2, M=8, BYPASS_SELECTION=1)
REQ-032 Bits 1 (sym_start), 0 with sym_ready=1 -> sym_out=8'h01, sym_valid high for one cycle, the cycle after the second bit.
REQ-033 Bits 1 (sym_start), then 1 with sym_start, then 1 -> one frame_err pulse, single output 8'h03.
REQ-034 bypass=1, bits 1, 0, 1 with no sym_start -> outputs 8'h02, 8'h00, 8'h02 in order.
REQ-035 sym_ready=0, three symbols 8'h01, 8'h02, 8'h03 -> third dropped with overflow pulse; raising sym_ready yields 8'h01 then 8'h02.
REQ-036 Full buffer, push coinciding with a pop -> no overflow, order preserved.
REQ-037 rst_n low after the first bit of a symbol -> outputs 0 at once; after release, bits 0, 1 without sym_start are discarded and nothing is output.
